// File: rtl/eth_phy_prbs_pkg.sv
// Shared constants and helpers for the 10G PHY PRBS31 receive checker.
package eth_phy_prbs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_SYNC,
        ST_LOCKED
    } prbs_state_t;

    localparam int PRBS_TAP_A = 31;
    localparam int PRBS_TAP_B = 28;
    localparam int FRAME_LEN  = 66;
    localparam int POPCOUNT_W = 7;

    function automatic logic [POPCOUNT_W-1:0] popcount(input logic [FRAME_LEN-1:0] v);
        logic [POPCOUNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < FRAME_LEN; i++) begin
            c = c + POPCOUNT_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_phy_10g_rx_prbs31_check_if.sv
// Serdes receive bus (payload plus sync header) watched by the PRBS31 checker.
interface eth_phy_10g_rx_prbs31_check_if #(
    parameter int DATA_WIDTH = 64,
    parameter int HDR_WIDTH  = 2
);
    logic [DATA_WIDTH-1:0] serdes_rx_data;
    logic [HDR_WIDTH-1:0]  serdes_rx_hdr;

    modport master (output serdes_rx_data, output serdes_rx_hdr);
    modport slave  (input  serdes_rx_data, input  serdes_rx_hdr);
endinterface

// File: rtl/eth_phy_prbs31_rx_step.sv
// Combinational one-block PRBS31 check: error vector, next history and all-zero flag.
module eth_phy_prbs31_rx_step
    import eth_phy_prbs_pkg::*;
(
    input  logic [PRBS_TAP_A-1:0] hist,
    input  logic [FRAME_LEN-1:0]  frame,
    output logic [FRAME_LEN-1:0]  err,
    output logic [PRBS_TAP_A-1:0] hist_next,
    output logic                  all_zero
);

    // ext[j] is the bit 31 positions before frame bit j, so taps become fixed slices.
    logic [FRAME_LEN+PRBS_TAP_A-1:0] ext;

    assign ext       = {frame, hist};
    assign err       = frame
                     ^ ext[FRAME_LEN-1:0]
                     ^ ext[FRAME_LEN-1+(PRBS_TAP_A-PRBS_TAP_B) : PRBS_TAP_A-PRBS_TAP_B];
    assign hist_next = ext[FRAME_LEN+PRBS_TAP_A-1 -: PRBS_TAP_A];
    assign all_zero  = ~|frame;

endmodule

// File: rtl/eth_phy_10g_rx_prbs31_check.sv
// RX PRBS31 checker: lock FSM, per-block error report and saturating error total.
// Optional PRBS31_CHECK_BLOCK_CNT_EN adds a saturating count of blocks checked while locked.
module eth_phy_10g_rx_prbs31_check
    import eth_phy_prbs_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int HDR_WIDTH     = 2,
    parameter bit PRBS_INVERT   = 1'b1,
    parameter int LOCK_BLOCKS   = 4,
    parameter int LOSS_BLOCKS   = 4,
    parameter int ERR_CNT_WIDTH = 32
) (
    input  logic                       rx_clk,
    input  logic                       rx_rst,
    eth_phy_10g_rx_prbs31_check_if.slave serdes_rx,
    input  logic                       cfg_rx_prbs31_enable,
    input  logic                       cfg_clear_count,
    output logic                       prbs_lock,
    output logic                       prbs_err_block,
    output logic [POPCOUNT_W-1:0]      prbs_bit_err_count,
    output logic [ERR_CNT_WIDTH-1:0]   prbs_err_total
`ifdef PRBS31_CHECK_BLOCK_CNT_EN
    ,
    output logic [ERR_CNT_WIDTH-1:0]   prbs_block_count
`endif
);

    localparam int FRAME_W = DATA_WIDTH + HDR_WIDTH;
    localparam int GOOD_W  = $clog2(LOCK_BLOCKS + 1);
    localparam int BAD_W   = $clog2(LOSS_BLOCKS + 1);
    localparam int SUM_W   = ((ERR_CNT_WIDTH > POPCOUNT_W) ? ERR_CNT_WIDTH : POPCOUNT_W) + 1;

    function automatic logic [ERR_CNT_WIDTH-1:0] sat_add(input logic [ERR_CNT_WIDTH-1:0] acc,
                                                         input logic [SUM_W-1:0]         inc);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(acc) + inc;
        if (sum > SUM_W'({ERR_CNT_WIDTH{1'b1}})) return '1;
        return sum[ERR_CNT_WIDTH-1:0];
    endfunction

    prbs_state_t            state_q, state_d;
    logic [GOOD_W-1:0]      good_q, good_d;
    logic [BAD_W-1:0]       bad_q, bad_d;
    logic [PRBS_TAP_A-1:0]  hist_q, hist_next;
    logic [FRAME_W-1:0]     frame_raw, frame_p0;
    logic [FRAME_LEN-1:0]   err_vec;
    logic [POPCOUNT_W-1:0]  err_cnt;
    logic                   all_zero, clean, checking;

    // Frame in line order: header bits first, so they sit in the LSBs.
    assign frame_raw = {serdes_rx.serdes_rx_data, serdes_rx.serdes_rx_hdr};
    assign frame_p0  = PRBS_INVERT ? ~frame_raw : frame_raw;

    eth_phy_prbs31_rx_step u_step (
        .hist      (hist_q),
        .frame     (frame_p0),
        .err       (err_vec),
        .hist_next (hist_next),
        .all_zero  (all_zero)
    );

    assign err_cnt  = popcount(err_vec);
    assign clean    = (err_cnt == '0);
    assign checking = cfg_rx_prbs31_enable && (state_q == ST_LOCKED);

    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            state_q <= ST_IDLE;
            good_q  <= '0;
            bad_q   <= '0;
            hist_q  <= '0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
            if (cfg_rx_prbs31_enable) hist_q <= hist_next;
        end
    end

    always_comb begin
        state_d = state_q;
        good_d  = '0;
        bad_d   = '0;
        if (cfg_rx_prbs31_enable) begin
            unique case (state_q)
                ST_IDLE: state_d = ST_FILL;
                ST_FILL: state_d = ST_SYNC;
                ST_SYNC: begin
                    if (clean && !all_zero) begin
                        if (good_q == GOOD_W'(LOCK_BLOCKS - 1)) state_d = ST_LOCKED;
                        else                                    good_d  = good_q + GOOD_W'(1);
                    end
                end
                ST_LOCKED: begin
                    if (!clean) begin
                        if (bad_q == BAD_W'(LOSS_BLOCKS - 1)) state_d = ST_SYNC;
                        else                                  bad_d   = bad_q + BAD_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else begin
            state_d = ST_IDLE;
        end
    end

    // Output stage: everything reflects the block sampled on this edge.
    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            prbs_lock          <= 1'b0;
            prbs_err_block     <= 1'b0;
            prbs_bit_err_count <= '0;
            prbs_err_total     <= '0;
        end else begin
            prbs_lock          <= (state_d == ST_LOCKED);
            prbs_err_block     <= checking && !clean;
            prbs_bit_err_count <= checking ? err_cnt : '0;
            if (cfg_clear_count)  prbs_err_total <= '0;
            else if (checking)    prbs_err_total <= sat_add(prbs_err_total, SUM_W'(err_cnt));
        end
    end

`ifdef PRBS31_CHECK_BLOCK_CNT_EN
    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst)               prbs_block_count <= '0;
        else if (cfg_clear_count) prbs_block_count <= '0;
        else if (checking)        prbs_block_count <= sat_add(prbs_block_count, SUM_W'(1));
    end
`endif

endmodule

// File: tb/tb_eth_phy_10g_rx_prbs31_check.sv
// Randomised bench for the PRBS31 checker, scored against a stream-level reference model.
module tb_eth_phy_10g_rx_prbs31_check;

    localparam int M_IDLE = 0, M_FILL = 1, M_SYNC = 2, M_LOCKED = 3;
    localparam longint MAX32 = 64'hFFFF_FFFF;
    localparam longint MAX4  = 15;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b0;
    logic clr = 1'b0;
    logic cmp_en = 1'b0;

    int checks = 0;
    int failures = 0;

    eth_phy_10g_rx_prbs31_check_if rxif ();

    logic        lock32, eb32, lock4, eb4;
    logic [6:0]  cnt32, cnt4;
    logic [31:0] tot32;
    logic [3:0]  tot4;
`ifdef PRBS31_CHECK_BLOCK_CNT_EN
    logic [31:0] blk32;
    logic [3:0]  blk4;
`endif

    eth_phy_10g_rx_prbs31_check #(.ERR_CNT_WIDTH(32)) dut32 (
        .rx_clk(clk), .rx_rst(rst), .serdes_rx(rxif),
        .cfg_rx_prbs31_enable(en), .cfg_clear_count(clr),
        .prbs_lock(lock32), .prbs_err_block(eb32),
        .prbs_bit_err_count(cnt32), .prbs_err_total(tot32)
`ifdef PRBS31_CHECK_BLOCK_CNT_EN
        , .prbs_block_count(blk32)
`endif
    );

    eth_phy_10g_rx_prbs31_check #(.ERR_CNT_WIDTH(4)) dut4 (
        .rx_clk(clk), .rx_rst(rst), .serdes_rx(rxif),
        .cfg_rx_prbs31_enable(en), .cfg_clear_count(clr),
        .prbs_lock(lock4), .prbs_err_block(eb4),
        .prbs_bit_err_count(cnt4), .prbs_err_total(tot4)
`ifdef PRBS31_CHECK_BLOCK_CNT_EN
        , .prbs_block_count(blk4)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the post-invert bit stream itself, last 31 bits kept in a queue.
    bit     q[$];
    int     m_mode, m_good, m_bad;
    longint e_lock, e_eb, e_cnt, e_tot32, e_tot4, e_blk32, e_blk4;

    always @(posedge clk or posedge rst) begin : model
        logic [65:0] f;
        int   cnt, nmode, ngood, nbad;
        bit   p, nz, on;
        if (rst) begin
            q.delete();
            for (int i = 0; i < 31; i++) q.push_back(1'b0);
            m_mode <= M_IDLE; m_good <= 0; m_bad <= 0;
            e_lock <= 0; e_eb <= 0; e_cnt <= 0;
            e_tot32 <= 0; e_tot4 <= 0; e_blk32 <= 0; e_blk4 <= 0;
        end else begin
            cnt = 0; nz = 1'b0; on = 1'b0;
            nmode = M_IDLE; ngood = 0; nbad = 0;
            if (en) begin
                f  = ~{rxif.serdes_rx_data, rxif.serdes_rx_hdr};
                nz = (f != '0);
                for (int i = 0; i < 66; i++) begin
                    p = q[0] ^ q[3];
                    cnt += int'(f[i] ^ p);
                    q.push_back(f[i]);
                    void'(q.pop_front());
                end
                on = (m_mode == M_LOCKED);
                nmode = m_mode; ngood = 0; nbad = 0;
                case (m_mode)
                    M_IDLE: nmode = M_FILL;
                    M_FILL: nmode = M_SYNC;
                    M_SYNC: begin
                        ngood = (cnt == 0 && nz) ? m_good + 1 : 0;
                        if (ngood == 4) begin nmode = M_LOCKED; ngood = 0; end
                    end
                    default: begin
                        nbad = (cnt != 0) ? m_bad + 1 : 0;
                        if (nbad == 4) begin nmode = M_SYNC; nbad = 0; end
                    end
                endcase
            end
            m_mode <= nmode; m_good <= ngood; m_bad <= nbad;
            e_lock <= (nmode == M_LOCKED);
            e_eb   <= (on && cnt != 0);
            e_cnt  <= on ? cnt : 0;
            if (clr) begin
                e_tot32 <= 0; e_tot4 <= 0; e_blk32 <= 0; e_blk4 <= 0;
            end else if (on) begin
                e_tot32 <= (e_tot32 + cnt > MAX32) ? MAX32 : e_tot32 + cnt;
                e_tot4  <= (e_tot4  + cnt > MAX4)  ? MAX4  : e_tot4  + cnt;
                e_blk32 <= (e_blk32 + 1 > MAX32) ? MAX32 : e_blk32 + 1;
                e_blk4  <= (e_blk4  + 1 > MAX4)  ? MAX4  : e_blk4  + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("lock32", lock32, e_lock);
            chk("err_block32", eb32, e_eb);
            chk("bit_err_count32", cnt32, e_cnt);
            chk("err_total32", tot32, e_tot32);
            chk("lock4", lock4, e_lock);
            chk("err_total4", tot4, e_tot4);
`ifdef PRBS31_CHECK_BLOCK_CNT_EN
            chk("block_count32", blk32, e_blk32);
            chk("block_count4", blk4, e_blk4);
`endif
        end
    end

    // Line-side generator: inverted PRBS31, seed all ones.
    logic [30:0] g = '1;

    task automatic gen_block(output logic [63:0] d, output logic [1:0] h);
        logic [65:0] fr;
        logic s;
        for (int i = 0; i < 66; i++) begin
            s = g[0] ^ g[3];
            g = {s, g[30:1]};
            fr[i] = ~s;
        end
        d = fr[65:2];
        h = fr[1:0];
    endtask

    task automatic step(input logic [63:0] d, input logic [1:0] h, input logic e, input logic c);
        rxif.serdes_rx_data = d;
        rxif.serdes_rx_hdr  = h;
        en  = e;
        clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic prbs_step(input int flip, input logic e, input logic c);
        logic [63:0] d;
        logic [1:0]  h;
        gen_block(d, h);
        if (flip >= 2)      d[flip-2] = ~d[flip-2];
        else if (flip >= 0) h[flip]   = ~h[flip];
        step(d, h, e, c);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        rxif.serdes_rx_data = '0;
        rxif.serdes_rx_hdr  = '0;
        #2 rst = 1'b1;
        cmp_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        step('0, '0, 1'b0, 1'b0);
        chk("post_reset_lock", lock32, 0);
        chk("post_reset_total", tot32, 0);

        // Enable one cycle ahead of the stream, then FILL plus four clean blocks.
        step('0, '0, 1'b1, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            prbs_step(-1, 1'b1, 1'b0);
            if (k == 4) chk("lock_before_block5", lock32, 0);
        end
        chk("lock_after_block5", lock32, 1);
        chk("total_after_lock", tot32, 0);
        repeat (10) prbs_step(-1, 1'b1, 1'b0);

        prbs_step(12, 1'b1, 1'b0);
        chk("flip_bit_count", cnt32, 3);
        chk("flip_err_block", eb32, 1);
        chk("flip_total32", tot32, 3);
        chk("flip_total4", tot4, 3);
        chk("flip_lock_held", lock32, 1);
        prbs_step(-1, 1'b1, 1'b0);
        chk("err_block_pulse_end", eb32, 0);

        for (int k = 1; k <= 4; k++) begin
            step('0, '0, 1'b1, 1'b0);
            if (k == 3) chk("zeros_lock_held", lock32, 1);
        end
        chk("zeros_lock_drop", lock32, 0);
        chk("zeros_total4_sat", tot4, 15);
        repeat (6) step('0, '0, 1'b1, 1'b0);
        chk("zeros_no_relock", lock32, 0);

        repeat (8) prbs_step(-1, 1'b1, 1'b0);
        chk("relock", lock32, 1);
        prbs_step(30, 1'b1, 1'b1);
        chk("clear_beats_add", tot32, 0);
        chk("clear_block_flagged", eb32, 1);

        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 99);
            if (r < 3)       prbs_step(-1, 1'b0, $urandom_range(0, 29) == 0);
            else if (r < 6)  step('0, '0, 1'b1, $urandom_range(0, 29) == 0);
            else if (r < 16) prbs_step($urandom_range(0, 65), 1'b1, $urandom_range(0, 29) == 0);
            else             prbs_step(-1, 1'b1, $urandom_range(0, 29) == 0);
        end

        repeat (8) prbs_step(-1, 1'b1, 1'b0);
        chk("lock_before_reset", lock32, 1);
        rst = 1'b1;
        #1;
        chk("async_reset_lock", lock32, 0);
        chk("async_reset_total", tot32, 0);
        chk("async_reset_count", cnt32, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            prbs_step(-1, 1'b1, 1'b0);
            if (k == 5) chk("relock_after_reset_early", lock32, 0);
        end
        chk("relock_after_reset", lock32, 1);
        step('0, '0, 1'b0, 1'b0);
        chk("enable_drop_lock", lock32, 0);
        repeat (2) step('0, '0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
